// File: rtl/uart_pkg.sv
// Shared types and constants for the scope serial command link.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;
    localparam int CMD_BYTES        = 3;
    localparam int FRAME_BITS       = 10;

    typedef enum logic [1:0] {
        IDLE,
        BYTE_HI,
        BYTE_MID,
        BYTE_LO
    } cmd_tx_state_t;

    typedef logic [23:0] cmd_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 byte serialiser; a trmt on the tx_done cycle chains frames
// with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       TX,
    output logic       tx_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic          active;
    logic          baud_tc;

    assign baud_tc = active && (baud_cnt == BAUD_LAST);
    assign tx_done = baud_tc && (bit_cnt == BIT_LAST);

    // Line is the LSB of the shift register, so TX comes straight off a flop.
    assign TX = shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '1;
            active   <= 1'b0;
        end else if (trmt) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= {1'b1, tx_data, 1'b0};
            active   <= 1'b1;
        end else if (active) begin
            if (baud_tc) begin
                baud_cnt <= '0;
                shift    <= {1'b1, shift[9:1]};
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    active  <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// 24-bit command transmitter: three back-to-back 8N1 frames, MSB byte
// first, with a sticky completion flag.
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_cmplt
);

    cmd_tx_state_t state;
    cmd_tx_state_t nxt;
    cmd_t          shadow;
    logic          accept;
    logic          trmt;
    logic          tx_done;
    logic [7:0]    tx_data;

    assign accept = snd_cmd && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (accept)  nxt = BYTE_HI;
            BYTE_HI:  if (tx_done) nxt = BYTE_MID;
            BYTE_MID: if (tx_done) nxt = BYTE_LO;
            BYTE_LO:  if (tx_done) nxt = IDLE;
            default:               nxt = IDLE;
        endcase
    end

    // The first byte is taken from cmd directly so its start bit lands
    // on the cycle after acceptance; later bytes come from the shadow.
    always_comb begin
        busy    = 1'b1;
        trmt    = 1'b0;
        tx_data = 8'h00;
        unique case (state)
            IDLE: begin
                busy    = 1'b0;
                trmt    = accept;
                tx_data = cmd[23:16];
            end
            BYTE_HI: begin
                trmt    = tx_done;
                tx_data = shadow[15:8];
            end
            BYTE_MID: begin
                trmt    = tx_done;
                tx_data = shadow[7:0];
            end
            BYTE_LO: begin
                trmt    = 1'b0;
                tx_data = 8'h00;
            end
            default: begin
                busy    = 1'b0;
                trmt    = 1'b0;
                tx_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            cmd_cmplt <= 1'b0;
        end else if (accept) begin
            shadow    <= cmd;
            cmd_cmplt <= 1'b0;
        end else if (state == BYTE_LO && tx_done) begin
            cmd_cmplt <= 1'b1;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk    (clk),
        .rst    (rst),
        .tx_data(tx_data),
        .trmt   (trmt),
        .TX     (TX),
        .tx_done(tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx: line traces compared against a
// frame-arithmetic model, plus mid-bit decoding of each command.
module tb_uart_cmd_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] cmd_a, cmd_b;
    logic        snd_a, snd_b;
    logic        tx_a, busy_a, cmplt_a;
    logic        tx_b, busy_b, cmplt_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_cmd_tx #(.BAUD_DIV(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_a),
        .snd_cmd  (snd_a),
        .TX       (tx_a),
        .busy     (busy_a),
        .cmd_cmplt(cmplt_a)
    );

    uart_cmd_tx #(.BAUD_DIV(2)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_b),
        .snd_cmd  (snd_b),
        .TX       (tx_b),
        .busy     (busy_b),
        .cmd_cmplt(cmplt_b)
    );

    function automatic logic get_tx(input int w);
        return (w != 0) ? tx_b : tx_a;
    endfunction

    function automatic logic get_busy(input int w);
        return (w != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic get_cmplt(input int w);
        return (w != 0) ? cmplt_b : cmplt_a;
    endfunction

    task automatic drive(input int w, input logic s, input logic [23:0] c);
        if (w != 0) begin
            snd_b = s;
            cmd_b = c;
        end else begin
            snd_a = s;
            cmd_a = c;
        end
    endtask

    // Expected line level j cycles after the acceptance edge.
    function automatic logic exp_tx(input logic [23:0] c, input int bd,
                                    input int j);
        int idx, b, k;
        logic [7:0] byt;
        if (j < 1 || j > 30 * bd) return 1'b1;
        idx = (j - 1) / bd;
        b   = idx / 10;
        k   = idx % 10;
        byt = 8'(c >> (8 * (2 - b)));
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return byt[k-1];
    endfunction

    // Starts at a negedge, ends at the negedge of cycle k+1+30*bd.
    task automatic run_cmd(input int w, input logic [23:0] c, input int bd,
                           input string nm, input bit disturb);
        int last;
        logic tr [0:255];
        logic [23:0] got;
        logic ob, oc;
        last = 30 * bd + 1;
        drive(w, 1'b1, c);
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            tr[j] = get_tx(w);
            ob    = get_busy(w);
            oc    = get_cmplt(w);
            checks++;
            if (tr[j] !== exp_tx(c, bd, j))
                $display("FAIL %s tx cyc %0d got %b exp %b",
                         nm, j, tr[j], exp_tx(c, bd, j));
            else passed++;
            checks++;
            if (ob !== (j <= 30 * bd))
                $display("FAIL %s busy cyc %0d got %b exp %b",
                         nm, j, ob, (j <= 30 * bd));
            else passed++;
            checks++;
            if (oc !== (j > 30 * bd))
                $display("FAIL %s cmplt cyc %0d got %b exp %b",
                         nm, j, oc, (j > 30 * bd));
            else passed++;
            if (j == 1) drive(w, 1'b0, disturb ? 24'hFFFFFF : c);
            if (disturb && j == 50) drive(w, 1'b1, 24'h0936CA);
            if (disturb && j == 51) drive(w, 1'b0, 24'hFFFFFF);
        end
        drive(w, 1'b0, 24'h000000);
        got = '0;
        for (int b = 0; b < 3; b++)
            for (int k = 1; k <= 8; k++)
                got[8 * (2 - b) + k - 1] = tr[(b * 10 + k) * bd + bd / 2 + 1];
        checks++;
        if (got !== c)
            $display("FAIL %s decoded got %h exp %h", nm, got, c);
        else passed++;
    endtask

    task automatic idle_watch(input int w, input int n, input logic cmplt_exp,
                              input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (get_tx(w) !== 1'b1 || get_busy(w) !== 1'b0 ||
                get_cmplt(w) !== cmplt_exp)
                bad++;
        end
        checks++;
        if (bad !== 0)
            $display("FAIL %s idle bad cycles got %0d exp 0", nm, bad);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1'b0, 24'h0);
        drive(1, 1'b0, 24'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_a, busy_a, cmplt_a} !== 3'b100)
            $display("FAIL reset_a got %b exp 100", {tx_a, busy_a, cmplt_a});
        else passed++;
        checks++;
        if ({tx_b, busy_b, cmplt_b} !== 3'b100)
            $display("FAIL reset_b got %b exp 100", {tx_b, busy_b, cmplt_b});
        else passed++;
        idle_watch(0, 200, 1'b0, "reset_idle");
    endtask

    task automatic test_basic;
        run_cmd(0, 24'h021ABC, 4, "basic", 1'b0);
    endtask

    task automatic test_back_to_back;
        run_cmd(0, 24'h0936CA, 4, "b2b", 1'b0);
    endtask

    task automatic test_ignore;
        @(negedge clk);
        run_cmd(0, 24'h021ABC, 4, "ignore", 1'b1);
        idle_watch(0, 150, 1'b1, "ignore_after");
    endtask

    task automatic test_random;
        logic [23:0] c;
        for (int i = 0; i < 6; i++) begin
            c = 24'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_cmd(0, c, 4, "random", 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] c;
        int bad;
        c = 24'($urandom);
        bad = 0;
        @(negedge clk);
        drive(0, 1'b1, c);
        for (int j = 1; j <= 55; j++) begin
            @(negedge clk);
            if (j == 1) drive(0, 1'b0, c);
            if (tx_a !== exp_tx(c, 4, j)) bad++;
        end
        checks++;
        if (bad !== 0)
            $display("FAIL rst_mid prefix bad cycles got %0d exp 0", bad);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx_a, busy_a, cmplt_a} !== 3'b100)
            $display("FAIL rst_mid got %b exp 100", {tx_a, busy_a, cmplt_a});
        else passed++;
        idle_watch(0, 100, 1'b0, "rst_mid_idle");
        run_cmd(0, 24'h123456, 4, "after_rst", 1'b0);
    endtask

    task automatic test_rst_vs_snd;
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 24'($urandom));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 24'h0);
        checks++;
        if ({tx_a, busy_a, cmplt_a} !== 3'b100)
            $display("FAIL rst_vs_snd got %b exp 100", {tx_a, busy_a, cmplt_a});
        else passed++;
        idle_watch(0, 50, 1'b0, "rst_vs_snd_idle");
    endtask

    task automatic test_baud2;
        run_cmd(1, 24'hA5005A, 2, "baud2", 1'b0);
        for (int i = 0; i < 3; i++)
            run_cmd(1, 24'($urandom), 2, "baud2_rand", 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore();
        test_random();
        test_reset_mid();
        test_rst_vs_snd();
        test_baud2();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
